// File: rtl/rice_block_sequencer.sv
// Rice block sequencer: steps a packet decode through option-ID fetch, block load,
// per-sample counting (coded or zero blocks) and packet completion.
//
// Ports
//   clk1        rising-edge clock
//   reset       synchronous active-high reset
//   start/stop  begin packet decode (IDLE only) / abort decode (any busy state)
//   n, j        sample width, samples per block (latched on accepted start)
//   pkt_blocks  blocks per packet (latched on accepted start)
//   id_valid/id option-ID handshake; id_ready is the registered accept indicator
//   sym_valid   datapath finished a sample; out_ready downstream ready
//   kcfg, mode  split value and coding mode (0 split, 1 FS, 2 no-comp, 3 zero)
//   blk_load    one-cycle datapath load pulse
//   dec_en      datapath enable (echo of out_ready while running)
//   zero_valid  one strobe per zero-block sample
//   smp_cnt     sample index in block; blk_cnt block index in packet
//   blk_done, pkt_done, busy, err  status
// All outputs are registered.
module rice_block_sequencer (
  input  logic       clk1,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [5:0] n,
  input  logic [5:0] j,
  input  logic [9:0] pkt_blocks,
  input  logic       id_valid,
  input  logic [4:0] id,
  input  logic       sym_valid,
  input  logic       out_ready,
  output logic       id_ready,
  output logic [5:0] kcfg,
  output logic [1:0] mode,
  output logic       blk_load,
  output logic       dec_en,
  output logic       zero_valid,
  output logic [5:0] smp_cnt,
  output logic [9:0] blk_cnt,
  output logic       blk_done,
  output logic       pkt_done,
  output logic       busy,
  output logic       err
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWaitId = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StZero   = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;
  localparam logic [2:0] StErr    = 3'd6;

  logic [2:0] state_q, state_d;
  logic [5:0] n_q, n_d, j_q, j_d;
  logic [9:0] pb_q, pb_d;
  logic [5:0] kcfg_q, kcfg_d;
  logic [1:0] mode_q, mode_d;
  logic [5:0] smp_q, smp_d;
  logic [9:0] blk_q, blk_d;
  logic       id_ready_q, id_ready_d;
  logic       blk_load_q, blk_load_d;
  logic       dec_en_q, dec_en_d;
  logic       zero_valid_q, zero_valid_d;
  logic       blk_done_q, blk_done_d;
  logic       pkt_done_q, pkt_done_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       count;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    j_d          = j_q;
    pb_d         = pb_q;
    kcfg_d       = kcfg_q;
    mode_d       = mode_q;
    smp_d        = smp_q;
    blk_d        = blk_q;
    dec_en_d     = 1'b0;
    zero_valid_d = 1'b0;
    blk_done_d   = 1'b0;
    count        = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          n_d   = n;
          j_d   = j;
          pb_d  = pkt_blocks;
          smp_d = '0;
          blk_d = '0;
          if (n == 6'd0 || j == 6'd0) begin
            state_d = StErr;
          end else if (pkt_blocks == 10'd0) begin
            state_d = StDone;
          end else begin
            state_d = StWaitId;
          end
        end
      end
      StWaitId: begin
        if (id_valid) begin
          if (id == 5'd0) begin
            state_d = StZero;
            mode_d  = 2'd3;
            kcfg_d  = '0;
          end else if (id == 5'd1) begin
            state_d = StLoad;
            mode_d  = 2'd1;
            kcfg_d  = '0;
          end else if (id == 5'd31) begin
            // Uncompressed block: the datapath reads raw n-bit samples.
            state_d = StLoad;
            mode_d  = 2'd2;
            kcfg_d  = n_q;
          end else if ({1'b0, id} <= n_q) begin
            state_d = StLoad;
            mode_d  = 2'd0;
            kcfg_d  = {1'b0, id} - 6'd1;
          end else begin
            state_d = StErr;
          end
        end
      end
      StLoad: begin
        smp_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        dec_en_d = out_ready;
        count    = sym_valid & out_ready;
      end
      StZero: begin
        zero_valid_d = out_ready;
        count        = out_ready;
      end
      StDone: begin
        smp_d   = '0;
        blk_d   = '0;
        state_d = StIdle;
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (count) begin
      if (smp_q == j_q - 6'd1) begin
        blk_done_d = 1'b1;
        smp_d      = '0;
        if (blk_q == pb_q - 10'd1) begin
          state_d = StDone;
        end else begin
          blk_d   = blk_q + 10'd1;
          state_d = StWaitId;
        end
      end else begin
        smp_d = smp_q + 6'd1;
      end
    end

    // Abort beats every other event; in IDLE a concurrent start wins instead.
    if (stop && state_q != StIdle) begin
      state_d      = StIdle;
      smp_d        = '0;
      blk_d        = '0;
      dec_en_d     = 1'b0;
      zero_valid_d = 1'b0;
      blk_done_d   = 1'b0;
    end

    id_ready_d = (state_d == StWaitId);
    blk_load_d = (state_d == StLoad);
    pkt_done_d = (state_d == StDone);
    busy_d     = (state_d != StIdle);
    err_d      = (state_d == StErr);
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q      <= StIdle;
      n_q          <= '0;
      j_q          <= '0;
      pb_q         <= '0;
      kcfg_q       <= '0;
      mode_q       <= '0;
      smp_q        <= '0;
      blk_q        <= '0;
      id_ready_q   <= 1'b0;
      blk_load_q   <= 1'b0;
      dec_en_q     <= 1'b0;
      zero_valid_q <= 1'b0;
      blk_done_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      j_q          <= j_d;
      pb_q         <= pb_d;
      kcfg_q       <= kcfg_d;
      mode_q       <= mode_d;
      smp_q        <= smp_d;
      blk_q        <= blk_d;
      id_ready_q   <= id_ready_d;
      blk_load_q   <= blk_load_d;
      dec_en_q     <= dec_en_d;
      zero_valid_q <= zero_valid_d;
      blk_done_q   <= blk_done_d;
      pkt_done_q   <= pkt_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign id_ready   = id_ready_q;
  assign kcfg       = kcfg_q;
  assign mode       = mode_q;
  assign blk_load   = blk_load_q;
  assign dec_en     = dec_en_q;
  assign zero_valid = zero_valid_q;
  assign smp_cnt    = smp_q;
  assign blk_cnt    = blk_q;
  assign blk_done   = blk_done_q;
  assign pkt_done   = pkt_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rice_block_sequencer.sv
module tb_rice_block_sequencer;

  logic       clk1 = 1'b0;
  logic       reset, start, stop, id_valid, sym_valid, out_ready;
  logic [5:0] n, j;
  logic [9:0] pkt_blocks;
  logic [4:0] id;
  logic       id_ready, blk_load, dec_en, zero_valid, blk_done, pkt_done, busy, err;
  logic [5:0] kcfg, smp_cnt;
  logic [1:0] mode;
  logic [9:0] blk_cnt;

  rice_block_sequencer dut (
    .clk1(clk1), .reset(reset), .start(start), .stop(stop), .n(n), .j(j),
    .pkt_blocks(pkt_blocks), .id_valid(id_valid), .id(id), .sym_valid(sym_valid),
    .out_ready(out_ready), .id_ready(id_ready), .kcfg(kcfg), .mode(mode),
    .blk_load(blk_load), .dec_en(dec_en), .zero_valid(zero_valid), .smp_cnt(smp_cnt),
    .blk_cnt(blk_cnt), .blk_done(blk_done), .pkt_done(pkt_done), .busy(busy), .err(err)
  );

  always #5 clk1 = ~clk1;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  // Packet-level reference state.
  int m_n, m_j, m_pb, m_blk;
  int n_loads, n_bd, zv_cnt;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {id_ready, kcfg, mode, blk_load, dec_en, zero_valid, smp_cnt, blk_cnt,
            blk_done, pkt_done, busy, err};
  endfunction

  // Option-ID table: returns legality, mode and split value.
  function automatic void decode(input int idv, input int nv, output bit ok,
                                 output int m, output int k);
    ok = 1'b1;
    if (idv == 0) begin m = 3; k = 0; end
    else if (idv == 1) begin m = 1; k = 0; end
    else if (idv == 31) begin m = 2; k = nv; end
    else if (idv >= 2 && idv <= nv) begin m = 0; k = idv - 1; end
    else begin ok = 1'b0; m = 0; k = 0; end
  endfunction

  task automatic start_pkt(input int nv, input int jv, input int pbv, input bit with_stop);
    n = 6'(nv); j = 6'(jv); pkt_blocks = 10'(pbv);
    start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
    n = 6'($urandom); j = 6'($urandom); pkt_blocks = 10'($urandom);
    m_n = nv; m_j = jv; m_pb = pbv; m_blk = 0;
    chk("start_busy", busy, 1);
    if (nv == 0 || jv == 0) begin
      chk("start_err", err, 1);
      chk("start_err_no_id_ready", id_ready, 0);
    end else if (pbv == 0) begin
      chk("empty_pkt_done", pkt_done, 1);
      chk("empty_no_id_ready", id_ready, 0);
    end else begin
      chk("start_id_ready", id_ready, 1);
      chk("start_smp_cnt", smp_cnt, 0);
      chk("start_blk_cnt", blk_cnt, 0);
      chk("start_err_clear", err, 0);
    end
  endtask

  task automatic finish_pkt();
    tick();
    chk("pkt_done_one_cycle", pkt_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_blk_cnt", blk_cnt, 0);
    chk("idle_smp_cnt", smp_cnt, 0);
    chk("idle_id_ready", id_ready, 0);
  endtask

  // rmode: 0 both held high, 1 out_ready toggles 1/0, 2 random.
  task automatic run_block(input int idv, input int rmode, input int stop_at,
                           output bit pkt_end);
    bit ok, sv, orr, counted, zero, last;
    int em, ek, acc, cyc;
    pkt_end = 1'b0;
    decode(idv, m_n, ok, em, ek);
    chk("wait_id_ready", id_ready, 1);
    id = 5'(idv); id_valid = 1'b1;
    tick();
    id_valid = 1'b0; id = 5'($urandom);
    chk("id_ready_drop", id_ready, 0);
    if (!ok) begin
      chk("bad_id_err", err, 1);
      chk("bad_id_busy", busy, 1);
      pkt_end = 1'b1;
      return;
    end
    chk("mode", mode, em);
    chk("kcfg", kcfg, ek);
    zero = (em == 3);
    if (!zero) begin
      chk("blk_load", blk_load, 1);
      if (blk_load) n_loads++;
      sym_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("load_one_cycle", blk_load, 0);
      chk("load_no_count", smp_cnt, 0);
    end else begin
      chk("zero_no_load", blk_load, 0);
    end
    acc = 0; cyc = 0;
    while (acc < m_j && cyc < 2000) begin
      case (rmode)
        0:       begin sv = 1'b1; orr = 1'b1; end
        1:       begin sv = 1'b1; orr = (cyc % 2 == 0); end
        default: begin sv = 1'(($urandom)); orr = 1'($urandom); end
      endcase
      if (acc == stop_at) begin
        stop = 1'b1; sym_valid = 1'b1; out_ready = 1'b1;
        tick();
        stop = 1'b0; sym_valid = 1'b0; out_ready = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_smp_cnt", smp_cnt, 0);
        chk("stop_blk_cnt", blk_cnt, 0);
        chk("stop_blk_done", blk_done, 0);
        chk("stop_pkt_done", pkt_done, 0);
        chk("stop_dec_en", dec_en, 0);
        pkt_end = 1'b1;
        return;
      end
      sym_valid = sv; out_ready = orr;
      tick();
      cyc++;
      counted = zero ? orr : (sv && orr);
      if (counted) acc++;
      chk("dec_en", dec_en, zero ? 0 : orr);
      chk("zero_valid", zero_valid, zero ? orr : 0);
      if (zero_valid) zv_cnt++;
      if (acc == m_j) begin
        last = (m_blk == m_pb - 1);
        chk("blk_done", blk_done, 1);
        if (blk_done) n_bd++;
        chk("smp_wrap", smp_cnt, 0);
        chk("pkt_done_at_end", pkt_done, last);
        if (!last) m_blk++;
        chk("blk_cnt", blk_cnt, m_blk);
        chk("next_id_ready", id_ready, !last);
        pkt_end = last;
      end else begin
        chk("no_blk_done", blk_done, 0);
        chk("smp_cnt", smp_cnt, acc);
      end
    end
    sym_valid = 1'b0; out_ready = 1'b0;
    chk("block_budget", cyc < 2000, 1);
  endtask

  initial begin
    bit e;
    int nv, jv, pbv, r, idv, guard;
    reset = 1'b1; start = 0; stop = 0; id_valid = 0; sym_valid = 0; out_ready = 0;
    n = 0; j = 0; pkt_blocks = 0; id = 0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", all_outs(), 0);

    // Split blocks, ids 3 then 3.
    n_loads = 0; n_bd = 0;
    start_pkt(10, 4, 2, 0);
    run_block(3, 0, -1, e);
    run_block(3, 0, -1, e);
    chk("two_blk_loads", n_loads, 2);
    chk("two_blk_dones", n_bd, 2);
    chk("pkt_end_seen", e, 1);
    finish_pkt();

    // Zero block, 32 samples, out_ready toggling.
    zv_cnt = 0;
    start_pkt(10, 32, 1, 0);
    run_block(0, 1, -1, e);
    chk("zero_pulses", zv_cnt, 32);
    finish_pkt();

    // Uncompressed then FS block; start+stop together in IDLE (start wins).
    start_pkt(10, 2, 2, 1);
    run_block(31, 0, -1, e);
    run_block(1, 2, -1, e);
    finish_pkt();

    // Illegal id -> ERR held until stop.
    start_pkt(10, 4, 1, 0);
    run_block(12, 0, -1, e);
    tick(); tick();
    chk("err_hold", err, 1);
    chk("err_busy", busy, 1);
    chk("err_no_id_ready", id_ready, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("err_cleared", err, 0);
    chk("err_exit_idle", busy, 0);

    // Abort at sample 2 of block 1.
    start_pkt(10, 4, 2, 0);
    run_block(3, 0, -1, e);
    run_block(3, 0, 2, e);
    tick();
    chk("stop_no_late_pkt_done", pkt_done, 0);

    // Empty packet.
    start_pkt(5, 3, 0, 0);
    finish_pkt();

    // n == 0 rejected at start.
    start_pkt(0, 3, 1, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("n0_err_cleared", err, 0);

    // j == 1 and j == 63 boundaries.
    start_pkt(7, 1, 2, 0);
    run_block(4, 0, -1, e);
    run_block(0, 0, -1, e);
    finish_pkt();
    start_pkt(20, 63, 1, 0);
    run_block(5, 0, -1, e);
    finish_pkt();

    // Reset mid-block overrides every other input.
    start_pkt(10, 4, 1, 0);
    id = 5'd3; id_valid = 1'b1; tick(); id_valid = 1'b0;
    tick();
    reset = 1'b1; stop = 1'b1; start = 1'b1; sym_valid = 1'b1; out_ready = 1'b1;
    id_valid = 1'b1;
    tick();
    reset = 1'b0; stop = 1'b0; start = 1'b0; sym_valid = 1'b0; out_ready = 1'b0;
    id_valid = 1'b0;
    chk("mid_reset_outputs", all_outs(), 0);
    tick();
    chk("mid_reset_idle", all_outs(), 0);

    // Randomised packets.
    for (int p = 0; p < 8; p++) begin
      nv = $urandom_range(2, 30); jv = $urandom_range(1, 6); pbv = $urandom_range(1, 3);
      start_pkt(nv, jv, pbv, 0);
      e = 1'b0; guard = 0;
      while (!e && guard < 10) begin
        guard++;
        if ($urandom_range(0, 2) == 0) begin
          // start outside IDLE must not disturb anything
          start = 1'b1; n = 6'($urandom); j = 6'($urandom); pkt_blocks = 10'($urandom);
          tick();
          start = 1'b0;
          chk("ignored_start_id_ready", id_ready, 1);
          chk("ignored_start_blk_cnt", blk_cnt, m_blk);
        end
        r = $urandom_range(0, 5);
        case (r)
          0:       idv = 0;
          1:       idv = 1;
          2:       idv = 31;
          3:       idv = (nv < 30) ? int'($urandom_range(nv + 1, 30)) : 0;
          default: idv = $urandom_range(2, nv);
        endcase
        run_block(idv, 2, -1, e);
      end
      chk("rand_pkt_budget", guard < 10 || e, 1);
      if (err) begin
        stop = 1'b1; tick(); stop = 1'b0;
        chk("rand_err_cleared", err, 0);
      end else begin
        finish_pkt();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
